// File: rtl/keyboardPkg.sv
// Shared keyboard constants and the scan-code assembler state type.
package keyboardPkg;

  // Upper half of a published key code for a break (key released) event.
  localparam logic [15:0] RELEASED     = 16'hF000;

  // A few common set-2 make codes.
  localparam logic [7:0]  KEY_A        = 8'h1C;
  localparam logic [7:0]  KEY_ENTER    = 8'h5A;
  localparam logic [7:0]  KEY_SPACE    = 8'h29;

  // Protocol bytes seen in the receive stream.
  localparam logic [7:0]  EXT_PREFIX   = 8'hE0;
  localparam logic [7:0]  BRK_PREFIX   = 8'hF0;
  localparam logic [7:0]  ACK          = 8'hFA;
  localparam logic [7:0]  BAT_OK       = 8'hAA;
  localparam logic [7:0]  PAUSE_PREFIX = 8'hE1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } asm_state_t;

endpackage

// File: rtl/seq_timeout.sv
// Silence counter: clears on clr_i, counts while en_i, and flags expiry
// when it sits on its last value with the count still enabled.
module seq_timeout #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/scan_code_assembler.sv
// Assembles PS/2 scan-code bytes (E0 extended / F0 break prefixes) into one
// 32-bit key code per key event, abandoning partial sequences on silence.
// Optional: define KEY_REPEAT_FILTER_EN to suppress typematic repeats of the
// most recently published make.
module scan_code_assembler
  import keyboardPkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] key_code,
  output logic        key_valid,
  output logic        busy,
  output logic        seq_err
);

  asm_state_t  state_q, state_d;
  logic [31:0] key_code_q, key_code_d;
  logic        key_valid_q, busy_q, seq_err_q;

  logic        pub;       // final byte of a sequence arrived
  logic        pub_ok;    // publish after repeat filtering
  logic        rel;       // published event is a break
  logic [15:0] code;      // {prefix, byte} of the published event
  logic        err_d;
  logic        expire;

  // Silence only matters inside a partial sequence.
  seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (rx_valid || (state_q == IDLE)),
    .en_i    (state_q != IDLE),
    .expire_o(expire)
  );

  // Next state and publish decision; a byte always beats a coincident expiry.
  always_comb begin
    state_d = state_q;
    pub     = 1'b0;
    rel     = 1'b0;
    code    = 16'h0000;
    err_d   = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == EXT_PREFIX)      state_d = EXT;
          else if (rx_data == BRK_PREFIX) state_d = BRK;
          else if (rx_data != ACK && rx_data != BAT_OK && rx_data != PAUSE_PREFIX) begin
            pub  = 1'b1;
            code = {8'h00, rx_data};
          end
        end
        EXT: begin
          if (rx_data == BRK_PREFIX)      state_d = EXT_BRK;
          else if (rx_data != EXT_PREFIX) begin
            pub     = 1'b1;
            code    = {EXT_PREFIX, rx_data};
            state_d = IDLE;
          end
        end
        BRK: begin
          if (rx_data == EXT_PREFIX)      state_d = EXT_BRK;
          else if (rx_data != BRK_PREFIX) begin
            pub     = 1'b1;
            rel     = 1'b1;
            code    = {8'h00, rx_data};
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          if (rx_data != EXT_PREFIX && rx_data != BRK_PREFIX) begin
            pub     = 1'b1;
            rel     = 1'b1;
            code    = {EXT_PREFIX, rx_data};
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (expire) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic [15:0] last_make_q, last_make_d;
  logic        last_vld_q, last_vld_d;

  // Drop a make identical to the last one still held down; breaks re-arm it.
  always_comb begin
    last_make_d = last_make_q;
    last_vld_d  = last_vld_q;
    pub_ok      = pub;
    if (pub && !rel) begin
      if (last_vld_q && code == last_make_q) begin
        pub_ok = 1'b0;
      end else begin
        last_make_d = code;
        last_vld_d  = 1'b1;
      end
    end else if (pub && rel && code == last_make_q) begin
      last_vld_d = 1'b0;
    end
  end

  // Repeat tracker registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_make_q <= 16'h0000;
      last_vld_q  <= 1'b0;
    end else begin
      last_make_q <= last_make_d;
      last_vld_q  <= last_vld_d;
    end
  end
`else
  assign pub_ok = pub;
`endif

  assign key_code_d = pub_ok ? {(rel ? RELEASED : 16'h0000), code} : key_code_q;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_code_q  <= 32'h0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= pub_ok;
      busy_q      <= (state_d != IDLE);
      seq_err_q   <= err_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_scan_code_assembler.sv
// Randomized + directed bench for scan_code_assembler against a prefix-flag
// reference model evaluated once per clock.
module tb_scan_code_assembler;
  import keyboardPkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] key_code;
  logic        key_valid, busy, seq_err;

  int total = 0;
  int bad   = 0;
  int pulses;

  // Reference model state
  bit          m_ext, m_brk, m_lv;
  int          m_sil;
  logic [15:0] m_lm;
  logic [31:0] m_code;
  bit          m_valid, m_busy, m_err;

  scan_code_assembler #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .key_code (key_code),
    .key_valid(key_valid),
    .busy     (busy),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge.
  function automatic void model_step(input bit r, input bit v, input logic [7:0] b);
    logic [15:0] c;
    bit is_rel, publish;
    m_valid = 0;
    m_err   = 0;
    if (r) begin
      m_ext = 0; m_brk = 0; m_sil = 0; m_lv = 0; m_lm = '0;
      m_code = '0; m_busy = 0;
      return;
    end
    if (v) begin
      m_sil = 0;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (!m_ext && !m_brk && (b == 8'hFA || b == 8'hAA || b == 8'hE1)) ;
      else begin
        c       = {(m_ext ? 8'hE0 : 8'h00), b};
        is_rel  = m_brk;
        publish = 1;
`ifdef KEY_REPEAT_FILTER_EN
        if (!is_rel) begin
          if (m_lv && c == m_lm) publish = 0;
          else begin m_lm = c; m_lv = 1; end
        end else if (c == m_lm) m_lv = 0;
`endif
        if (publish) begin
          m_code  = {(is_rel ? 16'hF000 : 16'h0000), c};
          m_valid = 1;
        end
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_sil++;
      if (m_sil == T) begin
        m_ext = 0; m_brk = 0; m_sil = 0; m_err = 1;
      end
    end
    m_busy = m_ext || m_brk;
  endfunction

  task automatic check_outs();
    chk("key_code",  key_code, m_code);
    chk("key_valid", 32'(key_valid), 32'(m_valid));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("seq_err",   32'(seq_err),   32'(m_err));
    if (key_valid) pulses++;
  endtask

  // One clock: check what the previous edge produced, then drive this cycle.
  task automatic tick(input bit r, input bit v, input logic [7:0] b);
    @(negedge clk);
    check_outs();
    rst = r; rx_valid = v; rx_data = b;
    model_step(r, v, b);
  endtask

  task automatic send(input logic [7:0] b);
    tick(0, 1, b);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00);
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [7:0] b;
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'hFA; pool[3] = 8'hAA;
    pool[4] = 8'hE1; pool[5] = 8'h1C; pool[6] = 8'h5A; pool[7] = 8'h29;
    pulses = 0;
    rst = 1; rx_valid = 0; rx_data = 8'h00;
    model_step(1, 0, 8'h00);
    tick(1, 0, 8'h00);
    tick(0, 0, 8'h00);

    // Plain make then break
    send(8'h1C); gap(2);
    send(8'hF0); gap(1); send(8'h1C); gap(2);
    // Extended make and extended break
    send(8'hE0); gap(1); send(8'h5A); gap(2);
    send(8'hE0); send(8'hF0); gap(1); send(8'h5A); gap(2);
    // Timeout after a lone break prefix, then a fresh make
    send(8'hF0); gap(T + 3);
    send(8'h29); gap(2);
    // Byte arriving exactly on the expiry cycle wins
    send(8'hE0); gap(T - 1); send(8'h12); gap(2);
    // Reset mid-sequence drops the prefix
    send(8'hE0); tick(1, 0, 8'h00); send(8'h23); gap(2);
    // Ignored bytes in IDLE; back-to-back break
    send(8'hFA); send(8'hAA); send(8'hE1); gap(1);
    send(8'hF0); send(8'h1B); gap(2);
    // Typematic repeat
    pulses = 0;
    send(8'h1C); send(8'h1C); send(8'h1C); gap(1);
`ifdef KEY_REPEAT_FILTER_EN
    chk("repeat_pulses", 32'(pulses), 32'd1);
`else
    chk("repeat_pulses", 32'(pulses), 32'd3);
`endif
    pulses = 0;
    send(8'hF0); send(8'h1C); send(8'h1C); gap(1);
    chk("rearm_pulses", 32'(pulses), 32'd2);

    // Random stream with occasional long silences and resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) tick(1, 0, 8'h00);
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      send(b);
      case ($urandom_range(0, 9))
        0:       gap($urandom_range(T - 2, T + 2));
        1, 2:    gap($urandom_range(1, 4));
        default: ;
      endcase
    end
    gap(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
